// File: rtl/nibble_add_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nibble_seq_pkg : shared constants, state encoding and index-width helper  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package nibble_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Never returns less than 1 so a single-nibble build still has an index bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_add_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nibble_add_seq_if : host start/done bus; ovf present with                |
// | NIBBLE_ADD_SEQ_OVF_EN. Rev 1.0 - initial release                          |
// +--------------------------------------------------------------------------+
interface nibble_add_seq_if
    import nibble_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) ();
    localparam int W = NIBBLE_W * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    logic         ovf;
`endif

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
`ifdef NIBBLE_ADD_SEQ_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
`ifdef NIBBLE_ADD_SEQ_OVF_EN
        , output ovf
`endif
    );

endinterface
`default_nettype wire

// File: rtl/nibble_add_seq_adder4_cell.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adder4_cell : combinational 4-bit ripple-carry adder with bit-3 carry-in  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module adder4_cell
    import nibble_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    input  logic                C0,
    output logic [NIBBLE_W-1:0] F,
    output logic                C4,
    output logic                c3
);
    logic w_c;

    always_comb begin
        F   = '0;
        c3  = 1'b0;
        w_c = C0;
        for (int i = 0; i < NIBBLE_W; i++) begin
            if (i == NIBBLE_W - 1) begin
                c3 = w_c;
            end
            F[i] = A[i] ^ B[i] ^ w_c;
            w_c  = (A[i] & B[i]) | (w_c & (A[i] ^ B[i]));
        end
        C4 = w_c;
    end

endmodule
`default_nettype wire

// File: rtl/nibble_add_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nibble_add_seq : wide adder reusing one 4-bit cell, LSB nibble first.     |
// | Optional ovf flag with NIBBLE_ADD_SEQ_OVF_EN. Rev 1.0 - initial release   |
// +--------------------------------------------------------------------------+
module nibble_add_seq
    import nibble_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    nibble_add_seq_if.slave   bus
);
    localparam int                W        = NIBBLE_W * NIBBLES;
    localparam int                IDX_W    = clog2(NIBBLES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic               carry_q;
    logic               cout_q;
    logic [IDX_W-1:0]   idx_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       sum_q;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    logic               ovf_q;
    logic               w_c3;
`else
    logic               w_c3_unused;
`endif

    logic [IDX_W+1:0]    w_lo;
    logic [NIBBLE_W-1:0] w_f;
    logic                w_c4;

    assign w_lo = {idx_q, 2'b00};

    adder4_cell u_cell (
        .A  (a_q[w_lo +: NIBBLE_W]),
        .B  (b_q[w_lo +: NIBBLE_W]),
        .C0 (carry_q),
        .F  (w_f),
        .C4 (w_c4),
`ifdef NIBBLE_ADD_SEQ_OVF_EN
        .c3 (w_c3)
`else
        .c3 (w_c3_unused)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_RUN: begin
                    sum_q[w_lo +: NIBBLE_W] <= w_f;
                    carry_q                 <= w_c4;
                    idx_q                   <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cout_q  <= w_c4;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
                        ovf_q   <= w_c3 ^ w_c4;
`endif
                    end
                end
                default: begin
                    // IDLE and DONE both accept; DONE re-accept gives back-to-back adds.
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
                        ovf_q   <= 1'b0;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_add_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nibble_add_seq : scoreboard bench for nibble_add_seq (NIBBLES=4)       |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_nibble_add_seq;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    nibble_add_seq_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_add_seq #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t       e;
        logic [W:0] t;
        t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return e;
    endfunction

    // Result monitor: every done pulse pops one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum",  bus.sum,  e.sum);
                check("cout", bus.cout, e.cout);
                check("busy_at_done", bus.busy, 0);
`ifdef NIBBLE_ADD_SEQ_OVF_EN
                check("ovf",  bus.ovf,  e.ovf);
`endif
            end
        end
    end

    task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                               input bit push);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.start = 1'b1;
        if (push) sb.push_back(model(a, b, cin));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!bus.done && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        if (!bus.done) check("done_timeout", 0, 1);
    endtask

    task automatic add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int cyc;
        pulse_start(a, b, cin, 1'b1);
        wait_done(cyc);
        check("latency", cyc, NIBBLES);
    endtask

    initial begin : stim
        int cyc;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sum",  bus.sum,  0);
        check("rst_cout", bus.cout, 0);
        rst_n = 1'b1;

        // Basic add with cycle-by-cycle busy/done profile.
        pulse_start(16'h0001, 16'h0001, 1'b0, 1'b1);
        check("busy_c0", bus.busy, 1);
        for (int i = 1; i < NIBBLES; i++) begin
            @(negedge clk);
            check("busy_run", bus.busy, 1);
            check("done_run", bus.done, 0);
        end
        @(negedge clk);
        check("done_pulse", bus.done, 1);
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
        check("idle_busy", bus.busy, 0);
        check("sum_hold", bus.sum, 16'h0002);

        add(16'h0000, 16'hFFFF, 1'b0);
        add(16'h0000, 16'hFFFF, 1'b1);
        add(16'hFFFF, 16'hFFFF, 1'b0);

        // Start during RUN is ignored; start held through DONE re-accepts.
        pulse_start(16'h1234, 16'h1111, 1'b0, 1'b1);
        @(negedge clk);
        bus.a = 16'hFFFF; bus.b = 16'h0001; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_ignored_start", bus.busy, 1);
        @(negedge clk);
        bus.a = 16'h0F0F; bus.b = 16'h00F1; bus.cin = 1'b0; bus.start = 1'b1;
        sb.push_back(model(16'h0F0F, 16'h00F1, 1'b0));
        @(negedge clk);
        check("overlap_done", bus.done, 1);
        @(negedge clk);
        bus.start = 1'b0;
        check("reaccept_busy", bus.busy, 1);
        check("reaccept_done", bus.done, 0);
        check("reaccept_sum_clr", bus.sum, 0);
        wait_done(cyc);
        check("b2b_latency", cyc, NIBBLES);

        // Asynchronous reset mid-operation.
        pulse_start(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_sum",  bus.sum,  0);
        check("abort_cout", bus.cout, 0);
        repeat (6) @(negedge clk);
        check("abort_no_done", bus.done, 0);
        rst_n = 1'b1;
        add(16'h0003, 16'h0004, 1'b0);

        add(16'h7FFF, 16'h0001, 1'b0);
        add(16'hFFFF, 16'h0001, 1'b0);
        add(16'h8000, 16'h8000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            add(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
